// File: rtl/alu_issue.sv
// Two-stage issue/writeback wrapper for RV32I OP and OP-IMM around an external combinational ALU.
// Stage D holds decoded operands that drive the ALU; stage W captures the result for the consumer.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;
    localparam int unsigned RW   = 5;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_OR   = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(3);
    localparam logic [OPW-1:0] OP_AND  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(5);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(7);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(9);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
        logic [RW-1:0]   rd;
        logic            illegal;
    } dec_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_rs1_field;

    assign opcode           = instr[6:0];
    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign unused_rs1_field = ^instr[19:15];

    // Instruction decode: operation select, legality and operand formation
    dec_t            dec_c;
    logic            is_op;
    logic            is_imm;
    logic            f7_base;
    logic            f7_alt;
    logic            legal;
    logic [OPW-1:0]  op_sel;
    logic [XLEN-1:0] imm_y;

    always_comb begin
        dec_c   = '0;
        is_op   = (opcode == OPC_OP);
        is_imm  = (opcode == OPC_OP_IMM);
        f7_base = (funct7 == F7_BASE);
        f7_alt  = (funct7 == F7_ALT);
        legal   = 1'b0;
        op_sel  = OP_ADD;
        imm_y   = {{(XLEN-12){instr[31]}}, instr[31:20]};

        if (is_op) begin
            legal = f7_base | (f7_alt & ((funct3 == 3'b000) | (funct3 == 3'b101)));
        end else if (is_imm) begin
            case (funct3)
                3'b001:  legal = f7_base;
                3'b101:  legal = f7_base | f7_alt;
                default: legal = 1'b1;
            endcase
        end

        case (funct3)
            3'b000:  op_sel = (is_op & f7_alt) ? OP_SUB : OP_ADD;
            3'b001:  op_sel = OP_SLL;
            3'b010:  op_sel = OP_SLT;
            3'b011:  op_sel = OP_SLTU;
            3'b100:  op_sel = OP_XOR;
            3'b101:  op_sel = f7_alt ? OP_SRA : OP_SRL;
            3'b110:  op_sel = OP_OR;
            default: op_sel = OP_AND;
        endcase

        // Shift-immediate forms carry only a 5-bit shamt in the immediate field
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
            imm_y = {(XLEN-5)'(0), instr[24:20]};
        end

        dec_c.rd = instr[11:7];
        if (legal) begin
            dec_c.op      = op_sel;
            dec_c.x       = rs1_val;
            dec_c.y       = is_op ? rs2_val : imm_y;
            dec_c.illegal = 1'b0;
        end else begin
            dec_c.illegal = 1'b1;
        end
    end

    // Pipeline state
    logic            d_valid_q, d_valid_d;
    dec_t            d_ent_q,   d_ent_d;
    logic            w_valid_q, w_valid_d;
    logic [RW-1:0]   w_rd_q,    w_rd_d;
    logic [XLEN-1:0] w_data_q,  w_data_d;
    logic            w_ill_q,   w_ill_d;

    logic w_free;
    logic d_adv;
    logic accept;

    // Handshake: D may advance whenever W is empty or draining this cycle
    always_comb begin
        w_free   = ~w_valid_q | out_ready;
        d_adv    = d_valid_q & w_free;
        in_ready = ~d_valid_q | d_adv;
        accept   = in_valid & in_ready;
    end

    always_comb begin
        d_valid_d = d_valid_q;
        d_ent_d   = d_ent_q;
        w_valid_d = w_valid_q;
        w_rd_d    = w_rd_q;
        w_data_d  = w_data_q;
        w_ill_d   = w_ill_q;

        if (d_adv) begin
            w_valid_d = 1'b1;
            w_rd_d    = d_ent_q.rd;
            w_data_d  = alu_o;
            w_ill_d   = d_ent_q.illegal;
        end else if (w_valid_q & out_ready) begin
            w_valid_d = 1'b0;
        end

        if (accept) begin
            d_valid_d = 1'b1;
            d_ent_d   = dec_c;
        end else if (d_adv) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_valid_q <= 1'b0;
            d_ent_q   <= '0;
            w_valid_q <= 1'b0;
            w_rd_q    <= '0;
            w_data_q  <= '0;
            w_ill_q   <= 1'b0;
        end else begin
            d_valid_q <= d_valid_d;
            d_ent_q   <= d_ent_d;
            w_valid_q <= w_valid_d;
            w_rd_q    <= w_rd_d;
            w_data_q  <= w_data_d;
            w_ill_q   <= w_ill_d;
        end
    end

    assign alu_op      = d_ent_q.op;
    assign alu_x       = d_ent_q.x;
    assign alu_y       = d_ent_q.y;
    assign out_valid   = w_valid_q;
    assign out_rd      = w_rd_q;
    assign out_data    = w_data_q;
    assign out_illegal = w_ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: ALU model on the alu_* bus, reference decode/execute scoreboard,
// directed steps followed by a random burst with random backpressure.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [3:0]  alu_op;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [31:0] alu_o;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    alu_issue dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_o      (alu_o),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_data   (out_data),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (alu_op)
            4'd0:    alu_o = alu_x + alu_y;
            4'd1:    alu_o = alu_x - alu_y;
            4'd2:    alu_o = alu_x | alu_y;
            4'd3:    alu_o = alu_x ^ alu_y;
            4'd4:    alu_o = alu_x & alu_y;
            4'd5:    alu_o = {31'd0, alu_x < alu_y};
            4'd6:    alu_o = {31'd0, $signed(alu_x) < $signed(alu_y)};
            4'd7:    alu_o = alu_x >> alu_y[4:0];
            4'd8:    alu_o = 32'($signed(alu_x) >>> alu_y[4:0]);
            4'd9:    alu_o = alu_x << alu_y[4:0];
            default: alu_o = 32'hDEAD_BEEF;
        endcase
    end

    // Architectural reference: what the writeback entry must contain
    function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        is_op;
        logic        is_imm;
        logic        ill;
        logic [31:0] y;
        logic [4:0]  sh;
        logic [31:0] r;
        opc    = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        is_op  = (opc == 7'h33);
        is_imm = (opc == 7'h13);
        ill    = !(is_op || is_imm);
        if (is_op)
            ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
        if (is_imm && f3 == 3'd1) ill = (f7 != 7'h00);
        if (is_imm && f3 == 3'd5) ill = !((f7 == 7'h00) || (f7 == 7'h20));
        y  = is_op ? b : {{20{ins[31]}}, ins[31:20]};
        sh = y[4:0];
        case (f3)
            3'd0:    r = (is_op && f7 == 7'h20) ? a - y : a + y;
            3'd1:    r = a << sh;
            3'd2:    r = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    r = (a < y) ? 32'd1 : 32'd0;
            3'd4:    r = a ^ y;
            3'd5:    r = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    r = a | y;
            default: r = a & y;
        endcase
        e.ill  = ill;
        e.rd   = ins[11:7];
        e.data = ill ? 32'd0 : r;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on every accepted input
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready)
            exp_q.push_back(ref_exec(instr, rs1_val, rs2_val));
    end

    // Scoreboard pop and compare on every delivered writeback entry
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_output observed rd=%0d data=%h expected no entry", out_rd, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 32'(out_rd), 32'(e.rd));
                chk("wb_data", out_data, e.data);
                chk("wb_illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        rs1_val  = a;
        rs2_val  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] f7;
        case ($urandom_range(0, 4))
            0, 1:    opc = 7'h33;
            2, 3:    opc = 7'h13;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    initial begin
        exp_t ea;
        exp_t eb;
        exp_t ec;
        logic accepted;
        logic [31:0] ia;
        logic [31:0] ib;
        logic [31:0] ic;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        rs1_val   = '0;
        rs2_val   = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_x", alu_x, 32'd0);
        chk("rst_alu_y", alu_y, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // addi x1, x0, -1 with rs1_val=5: sign-extended immediate
        send(32'hFFF00093, 32'd5, 32'd0);
        chk("addi_alu_op", 32'(alu_op), 32'd0);
        chk("addi_alu_x", alu_x, 32'd5);
        chk("addi_alu_y", alu_y, 32'hFFFF_FFFF);
        tick(1);
        chk("addi_out_valid", 32'(out_valid), 32'd1);
        chk("addi_out_rd", 32'(out_rd), 32'd1);
        chk("addi_out_data", out_data, 32'd4);

        // sub x1
        send(32'h400000B3, 32'd10, 32'd3);
        chk("sub_alu_op", 32'(alu_op), 32'd1);
        tick(1);
        chk("sub_out_data", out_data, 32'd7);

        // srai x1, x1, 4
        send(32'h4040D093, 32'h8000_0000, 32'd0);
        chk("srai_alu_op", 32'(alu_op), 32'd8);
        chk("srai_alu_y", alu_y, 32'd4);
        tick(1);
        chk("srai_out_data", out_data, 32'hF800_0000);

        // slt then sltu back to back
        in_valid = 1'b1;
        instr    = 32'h00002133;
        rs1_val  = 32'd1;
        rs2_val  = 32'hFFFF_FFFF;
        tick(1);
        instr    = 32'h00003133;
        tick(1);
        in_valid = 1'b0;
        chk("slt_out_valid", 32'(out_valid), 32'd1);
        chk("slt_out_data", out_data, 32'd0);
        chk("slt_out_rd", 32'(out_rd), 32'd2);
        tick(1);
        chk("sltu_out_valid", 32'(out_valid), 32'd1);
        chk("sltu_out_data", out_data, 32'd1);
        chk("sltu_out_rd", 32'(out_rd), 32'd2);

        // Illegal encodings still deliver an entry with zero data
        send(32'h00000073, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("ecall_alu_x", alu_x, 32'd0);
        tick(1);
        chk("ecall_out_valid", 32'(out_valid), 32'd1);
        chk("ecall_out_illegal", 32'(out_illegal), 32'd1);
        chk("ecall_out_data", out_data, 32'd0);
        send(32'h020001B3, 32'd7, 32'd9);
        tick(1);
        chk("f7_out_valid", 32'(out_valid), 32'd1);
        chk("f7_out_illegal", 32'(out_illegal), 32'd1);
        chk("f7_out_data", out_data, 32'd0);
        chk("f7_out_rd", 32'(out_rd), 32'd3);
        tick(3);

        // Backpressure: three instructions against a stalled consumer
        ia = 32'h00108233;
        ib = 32'h0020C333;
        ic = 32'h0020E3B3;
        rs1_val = $urandom;
        rs2_val = $urandom;
        ea = ref_exec(ia, rs1_val, rs2_val);
        eb = ref_exec(ib, rs1_val, rs2_val);
        ec = ref_exec(ic, rs1_val, rs2_val);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = ia;
        tick(1);
        chk("bp_ready_after_1", 32'(in_ready), 32'd1);
        instr = ib;
        tick(1);
        instr = ic;
        chk("bp_ready_after_2", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        tick(2);
        chk("bp_ready_held", 32'(in_ready), 32'd0);
        chk("bp_w_stable_data", out_data, ea.data);
        chk("bp_w_stable_rd", 32'(out_rd), 32'(ea.rd));
        out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("rel_b_valid", 32'(out_valid), 32'd1);
        chk("rel_b_data", out_data, eb.data);
        tick(1);
        chk("rel_c_valid", 32'(out_valid), 32'd1);
        chk("rel_c_data", out_data, ec.data);
        tick(1);
        chk("rel_empty", 32'(out_valid), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h00100093, 32'd1, 32'd0);
        send(32'h00200113, 32'd2, 32'd0);
        chk("full_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_alu_x", alu_x, 32'd0);
        tick(1);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(3);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);

        // Random burst with random backpressure
        accepted = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || accepted) begin
                instr    = rand_instr();
                rs1_val  = $urandom;
                rs2_val  = $urandom;
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        tick(2);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
